spike_aer_encoder: RTL and testbench

- Sits directly downstream of the neuron matrix.
- Captures each {tile address, tile spike vector} the matrix reports. The matrix has no backpressure, so capture is one entry per cycle into a small FIFO.
- Serialises each buffered vector into one address-event per set bit, carrying a flat neuron address, over a valid/ready handshake toward the spike router / off-chip AER link.
- Absorbs bursts from the matrix and flags any loss with a sticky overflow bit.

---
 rtl/aspen_pkg.sv | 21 ++
 rtl/spike_fifo.sv | 78 +++++++
 rtl/spike_aer_encoder.sv | 158 +++++++++++++++
 tb/tb_spike_aer_encoder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aspen_pkg.sv
// Shared definitions for the spike event path.
//   size_tile        : neurons per tile (width of one tile spike vector)
//   size_matrix      : tiles per neuron matrix
//   size_addr_matrix : tile address width
//   size_index       : bit index width inside one tile
//   size_addr_neuron : flat neuron address width ({tile, index})
//   ser_state_t      : serialiser FSM state encoding
package aspen_pkg;

    localparam int size_tile        = 4;
    localparam int size_matrix      = 16;
    localparam int size_addr_matrix = $clog2(size_matrix);
    localparam int size_index       = $clog2(size_tile);
    localparam int size_addr_neuron = size_addr_matrix + size_index;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/spike_fifo.sv
// Small synchronous FIFO of tile entries.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push       : write wr_data at the tail (caller guarantees room, or a
//                simultaneous pop when full)
//   pop        : advance the head (caller guarantees non-empty)
//   wr_data    : entry to write
//   rd_data    : current head entry, readable in the same cycle as pop
//   count      : registered occupancy
//   full/empty : occupancy flags derived from count
module spike_fifo #(
    parameter int width      = 8,
    parameter int depth      = 8,
    parameter int size_count = $clog2(depth) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [width-1:0]      wr_data,
    output logic [width-1:0]      rd_data,
    output logic [size_count-1:0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int ptr_w = $clog2(depth);

    // Storage carries no reset so it can map onto distributed RAM; the
    // head is read asynchronously so a pop hands over data in one cycle.
    logic [width-1:0] mem [depth];

    logic [ptr_w-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [ptr_w-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [size_count-1:0] count_reg, count_next;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers are exactly log2(depth) bits, so increment wraps modulo depth.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + ptr_w'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + ptr_w'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + size_count'(1);
            2'b01:   count_next = count_reg - size_count'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == size_count'(depth));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/spike_aer_encoder.sv
// Address-event encoder behind the neuron matrix.
// Captures non-zero {tile, spike vector} reports into a FIFO (no backpressure
// toward the matrix) and serialises each entry into one event per set bit,
// lowest bit first, over a valid/ready handshake.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   in_spikeValid     : matrix reports a spiking tile this cycle
//   in_spike          : spike vector of that tile
//   in_spikeAddress   : tile index
//   out_eventValid    : event presented (held until accepted)
//   out_eventReady    : consumer accepts the event
//   out_eventAddress  : flat neuron address {tile, bit index}
//   out_eventLast     : event is the last set bit of its tile entry
//   clear_overflow    : clears the sticky overflow flag
//   overflow          : sticky, a non-zero vector was dropped
//   fifo_count        : FIFO occupancy
//   busy              : FIFO non-empty or serialiser active
module spike_aer_encoder
    import aspen_pkg::*;
#(
    parameter int fifo_depth = 8,
    parameter int size_count = $clog2(fifo_depth) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_spikeValid,
    input  logic [size_tile-1:0]        in_spike,
    input  logic [size_addr_matrix-1:0] in_spikeAddress,
    output logic                        out_eventValid,
    input  logic                        out_eventReady,
    output logic [size_addr_neuron-1:0] out_eventAddress,
    output logic                        out_eventLast,
    input  logic                        clear_overflow,
    output logic                        overflow,
    output logic [size_count-1:0]       fifo_count,
    output logic                        busy
);

    localparam int entry_w = size_addr_matrix + size_tile;

    // Index of the lowest set bit; scanning downward leaves the lowest hit.
    function automatic logic [size_index-1:0] lowest_set(input logic [size_tile-1:0] v);
        lowest_set = '0;
        for (int i = size_tile - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = size_index'(i);
            end
        end
    endfunction

    ser_state_t                  state_reg, state_next;
    logic [size_addr_matrix-1:0] tile_reg, tile_next;
    logic [size_tile-1:0]        mask_reg, mask_next;
    logic                        overflow_reg, overflow_next;

    logic               push_req, push_ok, drop, pop;
    logic               fifo_full, fifo_empty;
    logic [entry_w-1:0] fifo_rd;
    logic               handshake;
    logic               last_bit;
    logic [size_tile-1:0] low_onehot;

    // Zero vectors carry no events, so they are never stored or counted
    // as lost. A full FIFO still accepts when the head leaves this cycle.
    assign push_req = in_spikeValid & (|in_spike);
    assign push_ok  = push_req & (~fifo_full | pop);
    assign drop     = push_req & fifo_full & ~pop;

    spike_fifo #(
        .width      (entry_w),
        .depth      (fifo_depth),
        .size_count (size_count)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_ok),
        .pop     (pop),
        .wr_data ({in_spikeAddress, in_spike}),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // x & -x isolates the lowest set bit; x & (x-1) == 0 means one bit left.
    assign low_onehot = mask_reg & (~mask_reg + size_tile'(1));
    assign last_bit   = ((mask_reg & (mask_reg - size_tile'(1))) == '0);
    assign handshake  = (state_reg == EMIT) & out_eventReady;

    always_comb begin
        state_next = state_reg;
        tile_next  = tile_reg;
        mask_next  = mask_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tile_next  = fifo_rd[entry_w-1:size_tile];
                    mask_next  = fifo_rd[size_tile-1:0];
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (handshake) begin
                    mask_next = mask_reg & ~low_onehot;
                    if (last_bit) begin
                        // Reload straight from the FIFO so back-to-back
                        // entries stream without an idle cycle.
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            tile_next = fifo_rd[entry_w-1:size_tile];
                            mask_next = fifo_rd[size_tile-1:0];
                        end else begin
                            tile_next  = '0;
                            mask_next  = '0;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A drop in the same cycle as a clear request wins.
    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clear_overflow) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            tile_reg     <= '0;
            mask_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tile_reg     <= tile_next;
            mask_reg     <= mask_next;
            overflow_reg <= overflow_next;
        end
    end

    assign out_eventValid   = (state_reg == EMIT);
    assign out_eventAddress = {tile_reg, lowest_set(mask_reg)};
    assign out_eventLast    = (state_reg == EMIT) & last_bit;
    assign overflow         = overflow_reg;
    assign busy             = ~fifo_empty | (state_reg != IDLE);

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;
    import aspen_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        in_spikeValid;
    logic [size_tile-1:0]        in_spike;
    logic [size_addr_matrix-1:0] in_spikeAddress;
    logic                        out_eventValid;
    logic                        out_eventReady;
    logic [size_addr_neuron-1:0] out_eventAddress;
    logic                        out_eventLast;
    logic                        clear_overflow;
    logic                        overflow;
    logic [CW-1:0]               fifo_count;
    logic                        busy;

    always #5 clk = ~clk;

    spike_aer_encoder #(
        .fifo_depth (DEPTH),
        .size_count (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_spikeValid    (in_spikeValid),
        .in_spike         (in_spike),
        .in_spikeAddress  (in_spikeAddress),
        .out_eventValid   (out_eventValid),
        .out_eventReady   (out_eventReady),
        .out_eventAddress (out_eventAddress),
        .out_eventLast    (out_eventLast),
        .clear_overflow   (clear_overflow),
        .overflow         (overflow),
        .fifo_count       (fifo_count),
        .busy             (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The FIFO is a queue of entries, the serialiser a "current entry" whose
    // remaining bits shrink as events are accepted.
    typedef struct packed {
        logic [3:0] tile;
        logic [3:0] mask;
    } ent_t;

    ent_t m_q[$];
    ent_t m_cur;
    bit   m_active;
    bit   m_ovf;
    int   exp_log[$];
    int   dut_addr[$];
    int   dut_last[$];
    int   dut_cyc[$];

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cur    = '0;
        m_active = 0;
        m_ovf    = 0;
    endtask

    task automatic model_step();
        bit   pop, hs, push_req, drop;
        ent_t e;
        int   li;
        hs  = m_active && out_eventReady;
        pop = 0;
        if (!m_active) pop = (m_q.size() > 0);
        else if (hs && $countones(m_cur.mask) == 1) pop = (m_q.size() > 0);
        push_req = in_spikeValid && (in_spike != 0);
        drop     = push_req && (m_q.size() >= DEPTH) && !pop;
        if (hs) begin
            li = lowest(m_cur.mask);
            exp_log.push_back(int'(m_cur.tile) * size_tile + li);
            m_cur.mask[li] = 1'b0;
            if (m_cur.mask == 0) m_active = 0;
        end
        if (pop) begin
            m_cur    = m_q.pop_front();
            m_active = 1;
        end
        if (push_req && !drop) begin
            e.tile = in_spikeAddress;
            e.mask = in_spike;
            m_q.push_back(e);
        end
        if (drop) m_ovf = 1;
        else if (clear_overflow) m_ovf = 0;
    endtask

    // One clock: log a DUT handshake, advance the model, then compare
    // every observable output against the model just after the edge.
    task automatic tick();
        if (out_eventValid && out_eventReady) begin
            dut_addr.push_back(int'(out_eventAddress));
            dut_last.push_back(int'(out_eventLast));
            dut_cyc.push_back(cyc);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("valid", int'(out_eventValid), int'(m_active));
        if (m_active) begin
            chk("address", int'(out_eventAddress), int'(m_cur.tile) * size_tile + lowest(m_cur.mask));
            chk("last", int'(out_eventLast), int'($countones(m_cur.mask) == 1));
        end
        chk("fifo_count", int'(fifo_count), m_q.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("busy", int'(busy), int'(m_active || m_q.size() > 0));
    endtask

    task automatic idle_inputs();
        in_spikeValid   = 0;
        in_spike        = '0;
        in_spikeAddress = '0;
        clear_overflow  = 0;
    endtask

    task automatic drain(input int limit);
        int k;
        in_spikeValid  = 0;
        out_eventReady = 1;
        k = 0;
        while ((m_active || m_q.size() > 0) && k < limit) begin
            tick();
            k++;
        end
        chk("drain_within_budget", int'(m_active || m_q.size() > 0), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  tile;
        logic [3:0]  spike;
        logic [15:0] rdy;   // ready per cycle, bit k = k cycles after the push
        int          n;
        int          addr[4];
    } vec_t;

    vec_t tbl[7];

    function automatic vec_t mk(input logic [3:0] t, input logic [3:0] s, input logic [15:0] r,
                                input int n, input int a0, input int a1, input int a2, input int a3);
        vec_t v;
        v.tile = t; v.spike = s; v.rdy = r; v.n = n;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
        return v;
    endfunction

    initial begin
        int base, push_cyc, k, lost;
        logic [3:0] one_bit;

        tbl[0] = mk(4'd3,  4'b0100, 16'hFFFF, 1, 14, 0, 0, 0);
        tbl[1] = mk(4'd5,  4'b1011, 16'hFFFF, 3, 20, 21, 23, 0);
        tbl[2] = mk(4'd2,  4'b1111, 16'hFFE7, 4, 8, 9, 10, 11);   // ready 1,0,0,1 from first valid
        tbl[3] = mk(4'd15, 4'b1000, 16'hFFFF, 1, 63, 0, 0, 0);
        tbl[4] = mk(4'd0,  4'b0001, 16'hFFFF, 1, 0, 0, 0, 0);
        tbl[5] = mk(4'd15, 4'b1111, 16'hFFFF, 4, 60, 61, 62, 63);
        tbl[6] = mk(4'd7,  4'b0110, 16'hF00F, 2, 29, 30, 0, 0);

        // ---- reset state ----
        reset = 1;
        idle_inputs();
        out_eventReady = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_eventValid), 0);
        chk("rst_address", int'(out_eventAddress), 0);
        chk("rst_last", int'(out_eventLast), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 0;

        // ---- table-driven single-tile vectors ----
        for (int r = 0; r < 7; r++) begin
            base            = dut_addr.size();
            in_spikeValid   = 1;
            in_spikeAddress = tbl[r].tile;
            in_spike        = tbl[r].spike;
            out_eventReady  = tbl[r].rdy[0];
            tick();
            push_cyc = cyc;
            idle_inputs();
            k = 1;
            while ((m_active || m_q.size() > 0) && k < 30) begin
                out_eventReady = (k < 16) ? tbl[r].rdy[k] : 1'b1;
                tick();
                k++;
            end
            chk("row_busy_end", int'(busy), 0);
            chk("row_event_count", dut_addr.size() - base, tbl[r].n);
            for (int i = 0; i < tbl[r].n && base + i < dut_addr.size(); i++) begin
                chk("row_addr", dut_addr[base + i], tbl[r].addr[i]);
                chk("row_last", dut_last[base + i], int'(i == tbl[r].n - 1));
                if (tbl[r].rdy == 16'hFFFF)
                    chk("row_timing", dut_cyc[base + i], push_cyc + 1 + i);
            end
            $display("row %0d tile=%0d spike=%b events=%0d", r, tbl[r].tile, tbl[r].spike, dut_addr.size() - base);
        end

        // ---- burst into a stalled consumer: overflow and clear ----
        out_eventReady = 0;
        base = dut_addr.size();
        for (int i = 0; i < 10; i++) begin
            in_spikeValid   = 1;
            in_spikeAddress = 4'(i);
            in_spike        = 4'b0001;
            tick();
        end
        idle_inputs();
        chk("burst_count_full", int'(fifo_count), 8);
        chk("burst_overflow", int'(overflow), 1);
        tick();
        chk("overflow_holds", int'(overflow), 1);
        clear_overflow = 1;
        tick();
        clear_overflow = 0;
        chk("overflow_cleared", int'(overflow), 0);
        drain(100);
        chk("burst_events", dut_addr.size() - base, 9);
        lost = 0;
        for (int i = base; i < dut_addr.size(); i++) begin
            chk("burst_addr", dut_addr[i], (i - base) * 4);
            if (dut_addr[i] == 36) lost++;
        end
        chk("burst_lost_absent", lost, 0);
        $display("burst: %0d events after stall", dut_addr.size() - base);

        // ---- valid with zero vector, then pointer wrap ----
        for (int i = 0; i < 3; i++) begin
            in_spikeValid   = 1;
            in_spikeAddress = 4'(i + 1);
            in_spike        = 4'b0000;
            tick();
            chk("zero_count", int'(fifo_count), 0);
            chk("zero_overflow", int'(overflow), 0);
        end
        base = dut_addr.size();
        out_eventReady = 1;
        for (int i = 0; i < 20; i++) begin
            one_bit         = 4'b0001 << (i % 4);
            in_spikeValid   = 1;
            in_spikeAddress = 4'(i % 16);
            in_spike        = one_bit;
            tick();
        end
        idle_inputs();
        drain(50);
        chk("wrap_events", dut_addr.size() - base, 20);
        for (int i = 0; i < 20 && base + i < dut_addr.size(); i++)
            chk("wrap_addr", dut_addr[base + i], (i % 16) * 4 + (i % 4));
        chk("wrap_overflow", int'(overflow), 0);
        $display("wrap: %0d events", dut_addr.size() - base);

        // ---- reset during emission ----
        out_eventReady  = 1;
        in_spikeValid   = 1;
        in_spikeAddress = 4'd1;
        in_spike        = 4'b0110;
        tick();
        in_spikeAddress = 4'd4;
        in_spike        = 4'b0001;
        tick();
        idle_inputs();
        tick();
        chk("pre_reset_valid", int'(out_eventValid), 1);
        chk("pre_reset_addr", int'(out_eventAddress), 6);
        #2;
        reset = 1;
        #1;
        chk("async_rst_valid", int'(out_eventValid), 0);
        chk("async_rst_count", int'(fifo_count), 0);
        chk("async_rst_busy", int'(busy), 0);
        model_reset();
        base = dut_addr.size();
        @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("post_reset_no_events", dut_addr.size() - base, 0);
        $display("reset mid-emission: %0d events after release", dut_addr.size() - base);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            in_spikeValid   = ($urandom_range(0, 99) < 60);
            in_spike        = 4'($urandom_range(0, 15));
            in_spikeAddress = 4'($urandom_range(0, 15));
            out_eventReady  = ($urandom_range(0, 99) < 65);
            clear_overflow  = ($urandom_range(0, 99) < 5);
            tick();
        end
        idle_inputs();
        drain(200);

        // ---- whole-run event stream vs model ----
        chk("total_events", dut_addr.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < dut_addr.size(); i++)
            chk("stream_addr", dut_addr[i], exp_log[i]);
        $display("stream: %0d events delivered", dut_addr.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
